// File: rtl/detector_stream_scheduler_pkg.sv
// Shared definitions for the detector stream scheduler.
// Contents:
//   state_t      - scheduler FSM encoding (IDLE, CLEAR, SHIFT, DRAIN, REPORT)
//   DEF_NREQ     - default number of requesters
//   DEF_WIDTH    - default word width
//   clog2_min1() - ceil(log2(value)), never less than 1
package detector_stream_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 8;

    // Width needed to index 'value' distinct items; at least 1 so that
    // single-item vectors stay legal.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/detector_stream_scheduler_if.sv
// Requester-side bus of the detector stream scheduler.
// Signals:
//   req[NREQ]          - per-requester request, held until granted
//   data[NREQ*WIDTH]   - requester i word at data[i*WIDTH +: WIDTH]
//   grant[NREQ]        - one-hot, one-cycle accept pulse
//   busy               - scheduler not in IDLE
//   done               - one-cycle result-valid pulse
//   done_id[IDW]       - requester ID of the reported word
//   match_count[CNTW]  - detector match count for the reported word
// Handshake: a requester raises req[i] with a stable word on its data
// slice and keeps both until it sees grant[i]=1; the word is taken on
// the rising edge that ends the grant cycle. done is a one-cycle valid
// with no back-pressure; done_id/match_count stay stable until the next
// report.
// Modports: master = requester side, slave = scheduler side.
interface detector_stream_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int IDW   = 1,
    parameter int CNTW  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CNTW-1:0]       match_count;

    modport master (
        output req, data,
        input  grant, busy, done, done_id, match_count
    );

    modport slave (
        input  req, data,
        output grant, busy, done, done_id, match_count
    );
endinterface

// File: rtl/detector_stream_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req[NREQ]   in  - request vector
//   ptr[IDW]    in  - highest-priority index for this scan
//   sel[NREQ]   out - one-hot winner (zero when no request)
//   sel_id[IDW] out - binary index of the winner
//   any         out - at least one request present
// The pointer register lives in the parent.
module detector_stream_scheduler_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDW-1:0]  sel_id,
    output logic            any
);

    function automatic int wrap_idx(input int base, input int offset);
        return (base + offset) % NREQ;
    endfunction

    // Scan ptr, ptr+1, ... wrapping; the first set bit wins.
    always_comb begin
        sel    = '0;
        sel_id = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[wrap_idx(int'(ptr), i)]) begin
                any                          = 1'b1;
                sel[wrap_idx(int'(ptr), i)]  = 1'b1;
                sel_id                       = IDW'(wrap_idx(int'(ptr), i));
            end
        end
    end

endmodule

// File: rtl/detector_stream_scheduler.sv
// Shares one serial sequence detector between NREQ requesters.
// A round-robin grant accepts one word; the detector is cleared for one
// cycle, the word is shifted MSB-first onto det_x, and det_z highs are
// counted and reported together with the requester ID.
// Ports:
//   clock      in  - rising-edge clock
//   reset      in  - synchronous active-low reset
//   bus        slave modport - req/data/grant/busy/done/done_id/match_count
//   det_rst    out - active-high detector reset
//   det_x      out - serial bit to the detector
//   det_z      in  - detector match output
//   dbg_state  out - current FSM state
module detector_stream_scheduler
    import detector_stream_scheduler_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = clog2_min1(NREQ),
    parameter int CNTW  = clog2_min1(WIDTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    detector_stream_scheduler_if.slave  bus,
    output logic                        det_rst,
    output logic                        det_x,
    input  logic                        det_z,
    output state_t                      dbg_state
);

    localparam int BW = clog2_min1(WIDTH);

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bit_idx;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_upd;
    logic [IDW-1:0]    id_reg;
    logic [IDW-1:0]    rr;
    logic [IDW-1:0]    res_id;
    logic [CNTW-1:0]   res_cnt;
    logic [NREQ-1:0]   arb_sel;
    logic [IDW-1:0]    arb_id;
    logic              arb_any;
    logic              sample_en;

    detector_stream_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (bus.req),
        .ptr    (rr),
        .sel    (arb_sel),
        .sel_id (arb_id),
        .any    (arb_any)
    );

    // z for bit k is seen during cycle k+1, so SHIFT cycle 0 carries a
    // stale z and is skipped; DRAIN carries the z of the last bit.
    assign sample_en = ((state == SHIFT) && (bit_idx != '0)) || (state == DRAIN);
    assign cnt_upd   = (sample_en && det_z && (cnt != '1)) ? cnt + CNTW'(1) : cnt;

    // Next state and outputs. Outputs are gated by reset so they read
    // idle values during the whole reset-asserted cycle.
    always_comb begin
        state_next      = state;
        bus.grant       = '0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.done_id     = res_id;
        bus.match_count = res_cnt;
        det_rst         = 1'b1;
        det_x           = 1'b0;
        dbg_state       = state;

        unique case (state)
            IDLE:    if (arb_any) state_next = CLEAR;
            CLEAR:   state_next = SHIFT;
            SHIFT:   if (bit_idx == BW'(WIDTH - 1)) state_next = DRAIN;
            DRAIN:   state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (reset) begin
            det_rst  = (state == CLEAR);
            bus.busy = (state != IDLE);
            bus.done = (state == REPORT);
            if (state == IDLE) begin
                bus.grant = arb_sel;
            end
            if (state == SHIFT) begin
                det_x = shreg[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            rr      <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            id_reg  <= '0;
            res_id  <= '0;
            res_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        shreg  <= bus.data[int'(arb_id) * WIDTH +: WIDTH];
                        id_reg <= arb_id;
                        rr     <= (int'(arb_id) == NREQ - 1) ? '0 : arb_id + IDW'(1);
                        cnt    <= '0;
                    end
                end
                CLEAR: begin
                    bit_idx <= '0;
                end
                SHIFT: begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_idx <= bit_idx + BW'(1);
                    cnt     <= cnt_upd;
                end
                DRAIN: begin
                    // Result registers hold after done falls, independent
                    // of the working counter cleared at the next grant.
                    cnt     <= cnt_upd;
                    res_cnt <= cnt_upd;
                    res_id  <= id_reg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detector_stream_scheduler.sv
module tb_detector_stream_scheduler;
    import detector_stream_scheduler_pkg::*;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int IDW   = 1;
    localparam int CNTW  = 4;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    logic   det_rst;
    logic   det_x;
    logic   det_z;
    logic   z_q = 1'b0;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [IDW+CNTW-1:0] exp_q[$];
    logic [IDW+CNTW-1:0] exp_item;

    detector_stream_scheduler_if #(
        .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)
    ) bus ();

    detector_stream_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .det_rst   (det_rst),
        .det_x     (det_x),
        .det_z     (det_z),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Stub detector: z is det_x delayed one cycle, cleared by det_rst.
    always @(posedge clock) begin
        if (det_rst) z_q <= 1'b0;
        else         z_q <= det_x;
    end
    assign det_z = z_q;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected report.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got id=%0d count=%0d required no report at %0t",
                         bus.done_id, bus.match_count, $time);
            end else begin
                exp_item = exp_q.pop_front();
                if ({bus.done_id, bus.match_count} !== exp_item) begin
                    errors++;
                    $display("FAIL report: got id=%0d count=%0d required id=%0d count=%0d at %0t",
                             bus.done_id, bus.match_count,
                             exp_item[IDW+CNTW-1 -: IDW], exp_item[CNTW-1:0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Waits (bounded) for a grant, checks it, queues the expected report,
    // then follows the word through CLEAR/SHIFT/DRAIN/REPORT.
    task automatic run_word(input logic [NREQ-1:0] exp_grant, input logic [IDW-1:0] exp_id,
                            input logic [WIDTH-1:0] word, input logic [CNTW-1:0] exp_cnt,
                            input logic [NREQ-1:0] next_req, input logic [NREQ*WIDTH-1:0] next_data,
                            output int waited);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant == '0 && n < 20);
        waited = n;
        if (bus.grant == '0) begin
            check("grant_timeout", 32'(bus.grant), 32'(exp_grant));
            return;
        end
        check("grant", 32'(bus.grant), 32'(exp_grant));
        exp_q.push_back({exp_id, exp_cnt});
        @(posedge clock);
        #1;
        bus.req  = next_req;
        bus.data = next_data;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            if (c == 1) begin
                check("clear_det_rst", 32'(det_rst), 1);
                check("clear_det_x", 32'(det_x), 0);
            end else if (c <= 9) begin
                check("shift_det_x", 32'(det_x), 32'(word[WIDTH-1-(c-2)]));
                if (c == 2) check("shift_det_rst", 32'(det_rst), 0);
            end else if (c == 10) begin
                check("drain_det_x", 32'(det_x), 0);
                check("drain_done", 32'(bus.done), 0);
            end else begin
                check("report_done", 32'(bus.done), 1);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int n;
        bus.req  = 2'b11;
        bus.data = {8'h5A, 8'b00100110};
        reset    = 1'b0;

        // Reset held two cycles with both requests present.
        repeat (2) begin
            @(negedge clock);
            check("rst_grant", 32'(bus.grant), 0);
            check("rst_done", 32'(bus.done), 0);
            check("rst_det_rst", 32'(det_rst), 1);
            check("rst_busy", 32'(bus.busy), 0);
        end
        @(posedge clock);
        #1 reset = 1'b1;

        // First grant goes to requester 0; single word 00100110 -> 3.
        run_word(2'b01, 1'b0, 8'b00100110, 4'd3, 2'b00, bus.data, w);
        @(negedge clock);
        check("hold_done_low", 32'(bus.done), 0);
        check("hold_count", 32'(bus.match_count), 3);
        check("hold_id", 32'(bus.done_id), 0);
        check("idle_busy", 32'(bus.busy), 0);

        // Isolation: 01 then 80 from requester 1, detector cleared between.
        @(posedge clock);
        #1;
        bus.req  = 2'b10;
        bus.data = {8'h01, 8'h00};
        run_word(2'b10, 1'b1, 8'h01, 4'd1, 2'b10, {8'h80, 8'h00}, w);
        run_word(2'b10, 1'b1, 8'h80, 4'd1, 2'b00, {8'h00, 8'h00}, w);
        check("iso_gap", 32'(11 + w), 12);

        // Round-robin with both requesting continuously.
        @(posedge clock);
        #1;
        bus.req  = 2'b11;
        bus.data = {8'h00, 8'hFF};
        run_word(2'b01, 1'b0, 8'hFF, 4'd8, 2'b11, {8'h00, 8'hFF}, w);
        run_word(2'b10, 1'b1, 8'h00, 4'd0, 2'b11, {8'h00, 8'hFF}, w);
        check("rr_gap1", 32'(11 + w), 12);
        run_word(2'b01, 1'b0, 8'hFF, 4'd8, 2'b00, {8'h00, 8'hFF}, w);
        check("rr_gap2", 32'(11 + w), 12);

        // Mid-word reset during SHIFT cycle 4 of an A5 word.
        @(posedge clock);
        #1;
        bus.req  = 2'b01;
        bus.data = {8'h00, 8'hA5};
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant == '0 && n < 20);
        check("mid_grant", 32'(bus.grant), 32'(2'b01));
        repeat (6) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_busy", 32'(bus.busy), 0);
        check("mid_det_x", 32'(det_x), 0);
        check("mid_done", 32'(bus.done), 0);
        check("mid_det_rst", 32'(det_rst), 1);
        check("mid_count_cleared", 32'(bus.match_count), 0);
        check("mid_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clock);
        #1 reset = 1'b1;
        run_word(2'b01, 1'b0, 8'hA5, 4'd4, 2'b00, {8'h00, 8'hA5}, w);

        repeat (4) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_stream_scheduler.md
Name: detector_stream_scheduler

Overview:
- Shares the serial sequence-detector datapath (ports clock, reset, x, z) between NREQ parallel requesters.
- Arbitrates round-robin and accepts one WIDTH-bit word per grant.
- Clears the detector, then serialises the word MSB-first onto the detector's x input, one bit per clock.
- Counts detector z assertions for that word and reports the count with the requester ID.

Parameters:
NREQ, 2, number of requesters
IDW, 1, requester ID width, ceil(log2(NREQ)), minimum 1
WIDTH, 8, bits per word
CNTW, 4, match counter width, ceil(log2(WIDTH+1))

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
req  in  NREQ  per-requester request; held until granted
data  in  NREQ*WIDTH  requester i word at data[i*WIDTH +: WIDTH]
grant  out  NREQ  one-hot, one-cycle accept pulse
busy  out  1  high in any state other than IDLE
det_rst  out  1  active-high reset to the detector
det_x  out  1  serial bit to the detector x input
det_z  in  1  detector z output
done  out  1  one-cycle result-valid pulse
done_id  out  IDW  requester ID of the reported word
match_count  out  CNTW  number of det_z highs for the reported word

Behaviour:
- While reset=0, at every edge:
  - FSM goes to IDLE; rr pointer = 0.
  - grant=0, done=0, done_id=0, match_count=0, busy=0, det_x=0, det_rst=1.
  - Applies mid-word as well: the word is dropped, no done pulse, no grant replay.
- FSM states: IDLE -> CLEAR -> SHIFT -> DRAIN -> REPORT -> IDLE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from rr, rr+1, ..., wrapping mod NREQ.
  - Pulse grant[sel] for this cycle; latch data[sel] into the shift register and sel into the ID register.
  - rr <= (sel+1) mod NREQ; clear the counter; go to CLEAR.
  - det_rst=0 and det_x=0 in IDLE.
- CLEAR: one cycle with det_rst=1, so no match spans two words. det_x=0.
- SHIFT: WIDTH cycles, bit index k = 0..WIDTH-1.
  - det_x = shreg[WIDTH-1]; shift left by one each edge.
  - The detector consumes bit k at the end of cycle k; its z for bit k is valid during cycle k+1.
  - At the edges ending SHIFT cycles k>=1, and at the edge ending the DRAIN cycle, if det_z=1 the counter increments, saturating at 2^CNTW-1.
  - Result: exactly WIDTH z samples per word; the z value sampled during cycle 0 (stale) is ignored.
- DRAIN: one cycle, det_x=0; final z sample taken.
- REPORT: one cycle.
  - done=1; done_id and match_count are driven from registers.
  - match_count and done_id hold their values after done falls, until the next REPORT or reset.
  - Next state IDLE.
- Latency: grant in cycle T; CLEAR T+1; SHIFT T+2..T+WIDTH+1; DRAIN T+WIDTH+2; done at T+WIDTH+3.
- Minimum grant-to-grant spacing: WIDTH+4 cycles.
- req/data are ignored outside IDLE; a requester that drops req before grant is simply not served.
- Simultaneous requests are resolved only by the rr scan. The same requester cannot win twice in a row while another requester is requesting.
- det_x=0 outside SHIFT; det_rst=0 outside reset and CLEAR.

Decomposition:
- Shared package:
  - State encoding typedef (IDLE, CLEAR, SHIFT, DRAIN, REPORT).
  - Default NREQ/WIDTH constants.
  - Helper function for ceil-log2.
- One natural sub-module, rr_arbiter: NREQ-wide round-robin picker.
  - Inputs: req, rr pointer.
  - Outputs: one-hot sel, binary ID, any-request flag.
  - Purely combinational; pointer register stays in the parent.
- Shift register, counter and FSM stay in the top.

Test Plan:
- Bench uses a stub detector: z = det_x registered one cycle, cleared by det_rst. Expected match_count = popcount(word).
- Reset: hold reset=0 for 2 cycles with req=2'b11 -> grant=0, done=0, det_rst=1, busy=0; first grant after release goes to requester 0.
- Single word: req[0]=1, data0=8'b00100110 -> grant=01 at T; det_x sequence 0,0,1,0,0,1,1,0 during T+2..T+9; done at T+11 with done_id=0, match_count=3.
- Round-robin: req=11 held continuously, data0=8'hFF, data1=8'h00 -> grants alternate 01,10,01, each 12 cycles apart; reports (0,8),(1,0),(0,8).
- Isolation:
  - Word 8'h01 then 8'h80, both from requester 1 -> det_rst pulses between words; counts 1 and 1.
  - det_x=0 in the CLEAR cycle.
- Mid-word reset: reset=0 during SHIFT cycle 4 -> next cycle busy=0, det_x=0, no done pulse. Re-request completes normally with the correct count.
